// File: rtl/noc_pkg.sv
// Shared NoC types: packet width, packet type, merge priority states, tagged FIFO entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

    localparam int WIDTH_PACKAGE = 33;

    typedef logic [WIDTH_PACKAGE-1:0] packet_t;

    // Which input wins when both offer a packet in the same cycle.
    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } pri_t;

    // Queued entry: source input index above the packet bits.
    typedef struct packed {
        logic    src;
        packet_t packet;
    } entry_t;

endpackage

// File: rtl/merge_arb_sync_fifo.sv
// Circular-buffer FIFO with count-based full/empty and a held head value while empty.
// Latency: a push at edge k is visible on head_data at edge k; pop consumes the head at an edge.
// Backpressure: push is ignored while full (even with a same-cycle pop); pop is ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last_head;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // While empty the output keeps showing the most recent head (zero after reset).
    assign head_data = empty ? last_head : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Track the head shown each non-empty cycle so it can be held once the FIFO drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_head <= '0;
        end else if (!empty) begin
            last_head <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/merge_arb.sv
// Two-input round-robin merge: one input packet per cycle tagged with its source into an output FIFO.
// Latency: packet accepted at edge k is on r_valid/r_data after edge k; earliest pop at edge k+1.
// Backpressure: input readies drop while the FIFO is full and stay low until a pop edge; r_ready never feeds the readies.
module merge_arb #(
    parameter int WIDTH_PACKAGE = noc_pkg::WIDTH_PACKAGE,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     l0_valid,
    output logic                     l0_ready,
    input  logic [WIDTH_PACKAGE-1:0] l0_data,
    input  logic                     l1_valid,
    output logic                     l1_ready,
    input  logic [WIDTH_PACKAGE-1:0] l1_data,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [WIDTH_PACKAGE-1:0] r_data,
    output logic                     r_src
);

    import noc_pkg::*;

    pri_t                   pri;
    logic [1:0]             grant;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [WIDTH_PACKAGE:0] push_entry;
    logic [WIDTH_PACKAGE:0] head_entry;

    // Grant: a lone requester wins outright; on contention the priority state decides.
    always_comb begin
        grant = 2'b00;
        if (l0_valid && l1_valid) begin
            grant = (pri == PRI0) ? 2'b01 : 2'b10;
        end else begin
            grant = {l1_valid, l0_valid};
        end
    end

    // Readies are gated by reset so an in-flight handshake is voided while rst_n is low.
    assign l0_ready = grant[0] & ~full & rst_n;
    assign l1_ready = grant[1] & ~full & rst_n;

    assign push       = l0_ready | l1_ready;
    assign push_entry = l1_ready ? {1'b1, l1_data} : {1'b0, l0_data};

    assign r_valid = ~empty;
    assign pop     = r_valid & r_ready;
    assign {r_src, r_data} = head_entry;

    // Priority FSM: after serving input N, the other input gets priority; idle cycles hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri <= PRI0;
        end else if (l0_ready) begin
            pri <= PRI1;
        end else if (l1_ready) begin
            pri <= PRI0;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH_PACKAGE + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_merge_arb.sv
// Bench for merge_arb: queue-based reference model checked every cycle, plus literal expectations.
// Latency: n/a.
// Backpressure: sources hold valid/data until the model says the packet was accepted.
module tb_merge_arb;

    import noc_pkg::*;

    localparam int DEPTH = 2;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    l0_valid = 1'b0;
    logic    l1_valid = 1'b0;
    logic    r_ready = 1'b0;
    packet_t l0_data = '0;
    packet_t l1_data = '0;
    logic    l0_ready;
    logic    l1_ready;
    logic    r_valid;
    packet_t r_data;
    logic    r_src;

    always #5 clk = ~clk;

    merge_arb #(
        .WIDTH_PACKAGE (WIDTH_PACKAGE),
        .DEPTH         (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .l0_valid (l0_valid),
        .l0_ready (l0_ready),
        .l0_data  (l0_data),
        .l1_valid (l1_valid),
        .l1_ready (l1_ready),
        .l1_data  (l1_data),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_data   (r_data),
        .r_src    (r_src)
    );

    int      vectors = 0;
    int      miscompares = 0;

    // Stimulus sources and the reference model state.
    packet_t src0[$];
    packet_t src1[$];
    logic    en0 = 1'b0;
    logic    en1 = 1'b0;
    entry_t  mq[$];
    entry_t  mlast;
    logic    mpri;
    entry_t  outlog[$];
    logic    glog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpri  = 1'b0;
        mlast = '0;
    endtask

    // Apply inputs from the source queues, then compare all outputs at the falling edge.
    task automatic drive_and_check();
        logic   full_m;
        logic   e0;
        logic   e1;
        entry_t e;
        l0_valid = en0 && (src0.size() > 0);
        l1_valid = en1 && (src1.size() > 0);
        if (src0.size() > 0) l0_data = src0[0];
        if (src1.size() > 0) l1_data = src1[0];
        @(negedge clk);
        full_m = (mq.size() == DEPTH);
        e0 = rst_n && l0_valid && !full_m && (!l1_valid || mpri == 1'b0);
        e1 = rst_n && l1_valid && !full_m && (!l0_valid || mpri == 1'b1);
        chk("l0_ready", l0_ready, e0);
        chk("l1_ready", l1_ready, e1);
        chk("r_valid", r_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("r_data", r_data, mq[0].packet);
            chk("r_src", r_src, mq[0].src);
        end else begin
            chk("r_data_held", r_data, mlast.packet);
            chk("r_src_held", r_src, mlast.src);
        end
        if (r_valid && r_ready) begin
            e.src    = r_src;
            e.packet = r_data;
            outlog.push_back(e);
        end
    endtask

    // Advance the model over one rising edge: pop, then at most one push under round robin.
    task automatic edge_step();
        int     sz;
        logic   a0;
        logic   a1;
        entry_t e;
        @(posedge clk);
        if (rst_n) begin
            sz = mq.size();
            a0 = l0_valid && (sz < DEPTH) && (!l1_valid || mpri == 1'b0);
            a1 = l1_valid && (sz < DEPTH) && (!l0_valid || mpri == 1'b1);
            if (sz > 0 && r_ready) mlast = mq.pop_front();
            if (a0) begin
                e.src = 1'b0; e.packet = l0_data;
                mq.push_back(e);
                mpri = 1'b1;
                glog.push_back(1'b0);
                void'(src0.pop_front());
            end
            if (a1) begin
                e.src = 1'b1; e.packet = l1_data;
                mq.push_back(e);
                mpri = 1'b0;
                glog.push_back(1'b1);
                void'(src1.pop_front());
            end
        end
        #1;
    endtask

    task automatic cycle();
        drive_and_check();
        edge_step();
    endtask

    task automatic drain();
        int n = 0;
        r_ready = 1'b1;
        while ((src0.size() > 0 || src1.size() > 0 || mq.size() > 0) && n < 40) begin
            cycle();
            n++;
        end
        if (n >= 40) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d cycles without emptying", n);
        end
    endtask

    initial begin
        model_reset();

        // Reset held with both inputs offering: nothing accepted, outputs at zero.
        src0.push_back(33'h100);
        src1.push_back(33'h200);
        en0 = 1'b1; en1 = 1'b1;
        repeat (2) begin
            drive_and_check();
            chk("rst_l0_ready", l0_ready, 1'b0);
            chk("rst_l1_ready", l1_ready, 1'b0);
            chk("rst_r_valid", r_valid, 1'b0);
            chk("rst_r_data", r_data, 33'h0);
            chk("rst_r_src", r_src, 1'b0);
            edge_step();
        end
        rst_n = 1'b1;
        drive_and_check();
        chk("first_grant_l0", l0_ready, 1'b1);
        chk("first_grant_l1", l1_ready, 1'b0);
        edge_step();
        drain();
        chk("rst_out_count", outlog.size(), 2);
        if (outlog.size() == 2) begin
            chk("rst_out0", {outlog[0].src, outlog[0].packet}, {1'b0, 33'h100});
            chk("rst_out1", {outlog[1].src, outlog[1].packet}, {1'b1, 33'h200});
        end

        // Backpressure: two accepts (0 then 1), readies low, resume one cycle after first pop.
        outlog.delete(); glog.delete();
        r_ready = 1'b0;
        src0.push_back(33'h0C0); src0.push_back(33'h0C1);
        src1.push_back(33'h0D0); src1.push_back(33'h0D1);
        cycle();
        cycle();
        drive_and_check();
        chk("bp_l0_ready", l0_ready, 1'b0);
        chk("bp_l1_ready", l1_ready, 1'b0);
        edge_step();
        cycle();
        chk("bp_accepts", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("bp_grant0", glog[0], 1'b0);
            chk("bp_grant1", glog[1], 1'b1);
        end
        r_ready = 1'b1;
        drive_and_check();
        chk("bp_pop_edge_l0_ready", l0_ready, 1'b0);
        edge_step();
        drive_and_check();
        chk("bp_resume_l0_ready", l0_ready, 1'b1);
        edge_step();
        drain();
        chk("bp_out_count", outlog.size(), 4);
        if (outlog.size() == 4) begin
            chk("bp_out0", {outlog[0].src, outlog[0].packet}, {1'b0, 33'h0C0});
            chk("bp_out1", {outlog[1].src, outlog[1].packet}, {1'b1, 33'h0D0});
            chk("bp_out2", {outlog[2].src, outlog[2].packet}, {1'b0, 33'h0C1});
            chk("bp_out3", {outlog[3].src, outlog[3].packet}, {1'b1, 33'h0D1});
        end

        // Full with a simultaneous pop: the pop edge does not push, the next edge does.
        outlog.delete();
        en0 = 1'b0;
        r_ready = 1'b0;
        src1.push_back(33'h0E0); src1.push_back(33'h0E1); src1.push_back(33'h0E2);
        cycle();
        cycle();
        r_ready = 1'b1;
        drive_and_check();
        chk("fp_block_l1_ready", l1_ready, 1'b0);
        chk("fp_full_r_valid", r_valid, 1'b1);
        edge_step();
        drive_and_check();
        chk("fp_next_l1_ready", l1_ready, 1'b1);
        edge_step();
        drain();
        chk("fp_out_count", outlog.size(), 3);
        if (outlog.size() == 3) begin
            chk("fp_out2", {outlog[2].src, outlog[2].packet}, {1'b1, 33'h0E2});
        end
        en0 = 1'b1;

        // Single stream on input 0: back-to-back outputs with no gaps.
        outlog.delete();
        en1 = 1'b0;
        r_ready = 1'b1;
        src0.push_back(33'h1); src0.push_back(33'h2); src0.push_back(33'h3);
        repeat (4) cycle();
        chk("ss_out_count", outlog.size(), 3);
        if (outlog.size() == 3) begin
            chk("ss_out0", {outlog[0].src, outlog[0].packet}, {1'b0, 33'h1});
            chk("ss_out1", {outlog[1].src, outlog[1].packet}, {1'b0, 33'h2});
            chk("ss_out2", {outlog[2].src, outlog[2].packet}, {1'b0, 33'h3});
        end
        drain();
        en1 = 1'b1;

        // Contention: both saturated; last grant was input 0, so grants run 1,0,1,0,...
        outlog.delete(); glog.delete();
        for (int i = 0; i < 6; i++) begin
            src0.push_back(33'h0A0 + 33'(i));
            src1.push_back(33'h0B0 + 33'(i));
        end
        drain();
        chk("ct_grants", glog.size(), 12);
        chk("ct_out_count", outlog.size(), 12);
        for (int i = 0; i < 12 && i < glog.size() && i < outlog.size(); i++) begin
            chk("ct_grant", glog[i], (i % 2 == 0) ? 1'b1 : 1'b0);
            if (i % 2 == 0)
                chk("ct_out", {outlog[i].src, outlog[i].packet}, {1'b1, 33'h0B0 + 33'(i / 2)});
            else
                chk("ct_out", {outlog[i].src, outlog[i].packet}, {1'b0, 33'h0A0 + 33'(i / 2)});
        end

        // Reset mid-operation: full FIFO discarded, priority returns to input 0.
        en1 = 1'b0;
        r_ready = 1'b0;
        src0.push_back(33'h0F0); src0.push_back(33'h0F2);
        cycle();
        cycle();
        cycle();
        outlog.delete(); glog.delete();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_r_valid", r_valid, 1'b0);
        chk("mr_r_data", r_data, 33'h0);
        #1;
        rst_n = 1'b1;
        en1 = 1'b1;
        r_ready = 1'b1;
        src0.push_back(33'h1F0);
        src1.push_back(33'h1F1);
        drive_and_check();
        chk("mr_first_l0_ready", l0_ready, 1'b1);
        chk("mr_first_l1_ready", l1_ready, 1'b0);
        edge_step();
        drain();
        chk("mr_out_count", outlog.size(), 2);
        if (outlog.size() == 2) begin
            chk("mr_out0", {outlog[0].src, outlog[0].packet}, {1'b0, 33'h1F0});
            chk("mr_out1", {outlog[1].src, outlog[1].packet}, {1'b1, 33'h1F1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/merge_arb.md
# merge_arb

Clocked two-input merge for NoC packets: the converging counterpart of the copy/fork stage, collapsing two packet streams into one. Each cycle at most one input packet is accepted under round-robin arbitration, tagged with its source, and queued in a small output FIFO that drives the downstream link. It sits wherever two router or PE streams converge onto a single channel.

## Interface
- WIDTH_PACKAGE, 33, packet width in bits.
- DEPTH, 2, output FIFO depth in entries (power of two, ≥2).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- l0_valid  in  1  input 0 offers a packet.
- l0_ready  out  1  input 0 packet accepted this cycle.
- l0_data  in  WIDTH_PACKAGE  input 0 packet.
- l1_valid  in  1  input 1 offers a packet.
- l1_ready  out  1  input 1 packet accepted this cycle.
- l1_data  in  WIDTH_PACKAGE  input 1 packet.
- r_valid  out  1  FIFO head valid.
- r_ready  in  1  downstream accepts head.
- r_data  out  WIDTH_PACKAGE  FIFO head packet.
- r_src  out  1  source input index of the head packet.

## Operation
- Transfer on any port occurs when valid and ready are both high at a rising edge.
- Inputs keep valid and data stable until accepted; the block never drops or duplicates a packet.
- Priority FSM with two states, PRI0 and PRI1; reset state PRI0.
- Grant: if exactly one input is valid, that input is granted. If both are valid, the input named by the FSM state is granted. If neither is valid, there is no grant.
- lN_ready = grant[N] & ~full. This is combinational from valid signals, FSM state and count; it never depends on r_ready.
- On accept from input N: push {N, lN_data}; the FSM moves to PRI(1-N). With no accept, the FSM holds.
- FIFO: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits with natural wrap-around, and count of log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- Pop when r_valid & r_ready. Push and pop in the same cycle leave count unchanged.
- Full blocks a push even if a pop occurs in the same cycle.
- r_valid = ~empty. r_data/r_src come from the head entry. When empty, r_data and r_src hold their last value; after reset that value is 0.
- Reset mid-operation: all queued packets are discarded. count=0, pointers=0, FSM=PRI0. Any in-flight input handshake is voided.

## Timing
- Reset values: l0_ready=0, l1_ready=0, r_valid=0, r_data=0, r_src=0.
- After rst_n deasserts, l0_ready and l1_ready may go high in the same cycle that the corresponding valid is high.
- Latency: a packet accepted at edge k is visible on r_valid/r_data at edge k (registered) and can be popped at edge k+1 at the earliest.
- Throughput: one packet per cycle in steady state with r_ready held high. With both inputs saturated, grants strictly alternate 0,1,0,1.
- Backpressure: once count hits DEPTH, both lN_ready are low until a pop edge has occurred.

## Structure
- Shared package noc_pkg holds:
  - the WIDTH_PACKAGE default constant;
  - typedef packet_t (logic [WIDTH_PACKAGE-1:0]);
  - enum pri_t {PRI0, PRI1};
  - the tagged-entry struct {src, packet}.
- One sub-module, sync_fifo: parameterized width and depth, with push/pop/full/empty ports. merge_arb contains only the arbiter FSM and grant logic.

## Test plan
- Reset: hold rst_n=0 with both valids high -> l0_ready=l1_ready=0, r_valid=0, r_data=0. Release rst_n -> first grant goes to input 0.
- Single stream: l0 sends 0x1, 0x2, 0x3 with r_ready=1 and l1 idle -> output is 0x1, 0x2, 0x3 on consecutive cycles, r_src=0, no gaps.
- Contention: both inputs valid continuously (l0=0xA.., l1=0xB..), r_ready=1 -> r_src sequence is 0,1,0,1 and each packet appears exactly once.
- Backpressure: r_ready=0, both valid -> exactly DEPTH=2 accepts (src 0 then 1), then both readies stay low. Raise r_ready -> order is preserved and accepts resume one cycle after the first pop.
- Full with simultaneous pop: FIFO full, r_ready=1, l1_valid=1 -> no push on the pop edge; push occurs on the next edge; count never exceeds 2.
- Reset mid-operation: FIFO holding 2 packets, pulse rst_n low between edges -> r_valid drops immediately, the queued packets never appear, and the FSM restarts at PRI0.
